// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters driving a 3-to-8 decoded resource.
// Registered grant index/one-hot grant with a bounded hold time per owner.
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       hold_timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       last;
    logic [2:0]       last_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       idx_nxt;
    logic             valid_nxt;
    logic             to_nxt;
    logic [7:0]       gnt_nxt;

    logic [2:0]       sel;
    logic [2:0]       cand;
    logic             found;
    logic             owner_req;
    logic             at_limit;

    // Search upward from the slot after the previous owner, wrapping; the
    // previous owner itself is examined last.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= 8; k++) begin
            cand = last + 3'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign owner_req = req[gnt_idx];
    assign at_limit  = (cnt >= HOLD_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last         <= 3'd7;
            cnt          <= '0;
            gnt          <= '0;
            gnt_idx      <= '0;
            gnt_valid    <= 1'b0;
            hold_timeout <= 1'b0;
        end else begin
            state        <= state_nxt;
            last         <= last_nxt;
            cnt          <= cnt_nxt;
            gnt          <= gnt_nxt;
            gnt_idx      <= idx_nxt;
            gnt_valid    <= valid_nxt;
            hold_timeout <= to_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en && found) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req || at_limit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        idx_nxt   = '0;
        valid_nxt = 1'b0;
        to_nxt    = 1'b0;
        cnt_nxt   = '0;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (en && found) begin
                    idx_nxt   = sel;
                    valid_nxt = 1'b1;
                    last_nxt  = sel;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            GRANT: begin
                if (owner_req && !at_limit) begin
                    idx_nxt   = gnt_idx;
                    valid_nxt = 1'b1;
                    cnt_nxt   = (cnt == '1) ? cnt : cnt + CNT_W'(1);
                end else begin
                    // Release while still requesting can only be a forced one.
                    to_nxt = owner_req;
                end
            end
            default: ;
        endcase
        gnt_nxt = valid_nxt ? (8'b1 << idx_nxt) : '0;
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed vector table, a rotation
// sequence and randomized traffic checked against a behavioural model.
module tb_rr_arbiter_8;

    localparam int unsigned MAXH = 4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       hold_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    rr_arbiter_8 #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req         (req),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .gnt_valid   (gnt_valid),
        .hold_timeout(hold_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       e;
        logic [7:0] q;
        int         idx;
        logic       v;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model: owner number, hold length, last owner.
    bit m_busy;
    int m_owner;
    int m_len;
    int m_last;
    bit m_to;

    task automatic model_step(input logic r, input logic e, input logic [7:0] q);
        if (r) begin
            m_busy = 0; m_owner = 0; m_len = 0; m_last = 7; m_to = 0;
        end else if (!m_busy) begin
            m_to = 0;
            if (e && q != 8'h00) begin
                for (int k = 1; k <= 8; k++) begin
                    if (!m_busy && q[(m_last + k) % 8]) begin
                        m_busy  = 1;
                        m_owner = (m_last + k) % 8;
                        m_last  = m_owner;
                        m_len   = 1;
                    end
                end
            end
        end else begin
            if (q[m_owner] && m_len < MAXH) begin
                m_len++;
                m_to = 0;
            end else begin
                m_to   = q[m_owner];
                m_busy = 0;
                m_len  = 0;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input int idx, input logic v, input logic to);
        int exp_gnt;
        exp_gnt = v ? (1 << idx) : 0;
        chk({tag, ".gnt_valid"}, int'(gnt_valid), int'(v));
        chk({tag, ".gnt_idx"}, int'(gnt_idx), v ? idx : 0);
        chk({tag, ".gnt"}, int'(gnt), exp_gnt);
        chk({tag, ".hold_timeout"}, int'(hold_timeout), int'(to));
    endtask

    task automatic step(input logic r, input logic e, input logic [7:0] q);
        @(negedge clk);
        rst = r; en = e; req = q;
        model_step(r, e, q);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic r, logic e, logic [7:0] q, int idx, logic v, logic to);
        vec_t x;
        x.r = r; x.e = e; x.q = q; x.idx = idx; x.v = v; x.to = to;
        return x;
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; req = 8'h00;
        m_busy = 0; m_owner = 0; m_len = 0; m_last = 7; m_to = 0;

        // Reset then idle
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0));
        // Priority after reset, then bubble and rotation to 7
        tbl.push_back(mk(0, 1, 8'h81, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'h80, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h80, 7, 1, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0));
        // Release before the hold limit
        tbl.push_back(mk(0, 1, 8'h04, 2, 1, 0));
        tbl.push_back(mk(0, 1, 8'h04, 2, 1, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0));
        // Enable gating around a grant to 3
        tbl.push_back(mk(0, 1, 8'h08, 3, 1, 0));
        tbl.push_back(mk(0, 0, 8'h09, 3, 1, 0));
        tbl.push_back(mk(0, 0, 8'h01, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h01, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h01, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h01, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0));
        // Reset mid-grant to 5 restores requester 0 priority
        tbl.push_back(mk(0, 1, 8'h20, 5, 1, 0));
        tbl.push_back(mk(1, 1, 8'h21, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h21, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].q);
            check_out($sformatf("vec%0d", i), tbl[i].idx, tbl[i].v, tbl[i].to);
        end

        // Full rotation with all requesting: 4 grant cycles then a timeout bubble
        step(1, 0, 8'h00);
        for (int t = 0; t < 45; t++) begin
            step(0, 1, 8'hFF);
            if (t % 5 < 4)
                check_out($sformatf("rot%0d", t), (t / 5) % 8, 1'b1, 1'b0);
            else
                check_out($sformatf("rot%0d", t), 0, 1'b0, 1'b1);
        end
        step(0, 1, 8'h00);
        check_out("rot_end", 0, 1'b0, 1'b0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            logic       r;
            logic       e;
            logic [7:0] q;
            r = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 5) != 0);
            q = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 3) == 0) q = 8'h00;
            step(r, e, q);
            check_out($sformatf("rnd%0d", c), m_owner, m_busy, m_to);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
